// File: rtl/lcd_controller.sv
// HD44780 16x2 character LCD driver, 8-bit write-only bus.
// Runs the power-up init once, then rewrites both lines from a 32-byte snapshot on each UpdateLCD edge.
module lcd_controller #(
  parameter int unsigned PWRUP_CYCLES = 750000,
  parameter int unsigned EN_CYCLES    = 25,
  parameter int unsigned CMD_WAIT     = 2500,
  parameter int unsigned CLEAR_WAIT   = 82000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0][7:0] ASCII,
  input  logic             UpdateLCD,
  output logic [7:0]       LCD_DATA,
  output logic             LCD_RS,
  output logic             LCD_RW,
  output logic             LCD_EN,
  output logic             LCD_ON,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CW = $clog2(PWRUP_CYCLES + CLEAR_WAIT + CMD_WAIT + EN_CYCLES + 1);

  typedef enum logic [1:0] {
    PWRUP   = 2'd0,
    INIT    = 2'd1,
    IDLE    = 2'd2,
    REFRESH = 2'd3
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [5:0]       idx_r;
  logic             upd_q_r;
  logic             pending_r;
  logic [31:0][7:0] frame_r;

  logic             edge_s;
  logic             last_s;
  logic [CW-1:0]    wait_end_s;
  logic [8:0]       next_byte_s;

  // {rs, data} for each step of the power-up command sequence
  function automatic logic [8:0] init_byte(input logic [5:0] idx);
    logic [8:0] b;
    case (idx)
      6'd0:    b = {1'b0, 8'h38};
      6'd1:    b = {1'b0, 8'h0C};
      6'd2:    b = {1'b0, 8'h06};
      6'd3:    b = {1'b0, 8'h01};
      default: b = {1'b0, 8'h00};
    endcase
    return b;
  endfunction

  // {rs, data} for each of the 34 refresh bytes: line-1 address, 16 chars, line-2 address, 16 chars
  function automatic logic [8:0] refresh_byte(input logic [5:0] idx, input logic [31:0][7:0] fr);
    logic [8:0] b;
    if (idx == 6'd0) begin
      b = {1'b0, 8'h80};
    end else if (idx <= 6'd16) begin
      b = {1'b1, fr[5'(idx - 6'd1)]};
    end else if (idx == 6'd17) begin
      b = {1'b0, 8'hC0};
    end else if (idx <= 6'd33) begin
      b = {1'b1, fr[5'(idx - 6'd2)]};
    end else begin
      b = {1'b0, 8'h00};
    end
    return b;
  endfunction

  assign LCD_RW = 1'b0;
  assign LCD_ON = 1'b1;

  // Trigger edge, post-byte wait length and the byte that follows the current one
  always_comb begin
    edge_s      = UpdateLCD & ~upd_q_r;
    wait_end_s  = (!LCD_RS && LCD_DATA == 8'h01) ? CW'(CLEAR_WAIT - 1) : CW'(CMD_WAIT - 1);
    last_s      = 1'b0;
    next_byte_s = 9'h000;
    if (state_r == INIT) begin
      last_s      = (idx_r == 6'd3);
      next_byte_s = init_byte(idx_r + 6'd1);
    end else begin
      last_s      = (idx_r == 6'd33);
      next_byte_s = refresh_byte(idx_r + 6'd1, frame_r);
    end
  end

  // Main sequencer: power-up wait, byte strobe timing, init/refresh stepping and trigger bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= PWRUP;
      cnt_r     <= '0;
      idx_r     <= 6'd0;
      upd_q_r   <= 1'b0;
      pending_r <= 1'b0;
      frame_r   <= '0;
      LCD_DATA  <= 8'h00;
      LCD_RS    <= 1'b0;
      LCD_EN    <= 1'b0;
      Busy      <= 1'b1;
      Done      <= 1'b0;
    end else begin
      upd_q_r <= UpdateLCD;
      Done    <= 1'b0;
      case (state_r)
        PWRUP: begin
          if (edge_s) pending_r <= 1'b1;
          if (cnt_r == CW'(PWRUP_CYCLES - 1)) begin
            state_r            <= INIT;
            idx_r              <= 6'd0;
            cnt_r              <= '0;
            {LCD_RS, LCD_DATA} <= init_byte(6'd0);
            LCD_EN             <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        INIT, REFRESH: begin
          if (edge_s) pending_r <= 1'b1;
          if (LCD_EN) begin
            if (cnt_r == CW'(EN_CYCLES - 1)) begin
              LCD_EN <= 1'b0;
              cnt_r  <= '0;
            end else begin
              cnt_r <= cnt_r + CW'(1'b1);
            end
          end else if (cnt_r == wait_end_s) begin
            // next byte's RS/DATA launch on the same edge the wait ends
            cnt_r <= '0;
            if (last_s) begin
              state_r <= IDLE;
              Busy    <= 1'b0;
              Done    <= (state_r == REFRESH);
            end else begin
              idx_r              <= idx_r + 6'd1;
              {LCD_RS, LCD_DATA} <= next_byte_s;
              LCD_EN             <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
          end
        end
        IDLE: begin
          if (pending_r || edge_s) begin
            frame_r            <= ASCII;
            pending_r          <= 1'b0;
            state_r            <= REFRESH;
            Busy               <= 1'b1;
            idx_r              <= 6'd0;
            cnt_r              <= '0;
            {LCD_RS, LCD_DATA} <= {1'b0, 8'h80};
            LCD_EN             <= 1'b1;
          end
        end
        default: begin
          state_r <= PWRUP;
          cnt_r   <= '0;
          LCD_EN  <= 1'b0;
          Busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller with shortened timing (PWRUP=20, EN=2, CMD_WAIT=5, CLEAR_WAIT=10).
module tb_lcd_controller;

  typedef logic [31:0][7:0] frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       UpdateLCD = 1'b0;
  frame_t     ascii = '0;
  logic [7:0] LCD_DATA;
  logic       LCD_RS, LCD_RW, LCD_EN, LCD_ON, Busy, Done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  frame_t frame_a, frame_b;

  lcd_controller #(
    .PWRUP_CYCLES(20),
    .EN_CYCLES   (2),
    .CMD_WAIT    (5),
    .CLEAR_WAIT  (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ASCII    (ascii),
    .UpdateLCD(UpdateLCD),
    .LCD_DATA (LCD_DATA),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_EN   (LCD_EN),
    .LCD_ON   (LCD_ON),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (Done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic frame_t mk_frame(input string l1, input string l2);
    frame_t f;
    for (int i = 0; i < 16; i++) begin
      f[i]      = l1[i];
      f[16 + i] = l2[i];
    end
    return f;
  endfunction

  task automatic check_reset_vals(input string tag);
    check(tag, 32'({LCD_DATA, LCD_RS, LCD_EN, LCD_RW, LCD_ON, Busy, Done}),
               32'({8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}));
  endtask

  // Follows one byte from EN rise to the end of its low window, checking value, timing and stability
  task automatic expect_byte(input string tag, input logic rs, input logic [7:0] d, input int wlow);
    int   g, hi, lo;
    logic ok;
    g = 0;
    while (!LCD_EN && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_start"}, 32'(LCD_EN), 32'd1);
    check({tag, "_byte"}, 32'({LCD_RS, LCD_DATA}), 32'({rs, d}));
    ok = 1'b1;
    hi = 0;
    while (LCD_EN && hi < 1000) begin
      if ({LCD_RS, LCD_DATA} !== {rs, d}) ok = 1'b0;
      hi++;
      @(negedge clk);
    end
    lo = 0;
    while (!LCD_EN && Busy && lo < 1000) begin
      if ({LCD_RS, LCD_DATA} !== {rs, d}) ok = 1'b0;
      lo++;
      @(negedge clk);
    end
    check({tag, "_en_hi"}, 32'(hi), 32'd2);
    check({tag, "_en_lo"}, 32'(lo), 32'(wlow));
    check({tag, "_stable"}, 32'(ok), 32'd1);
  endtask

  task automatic check_init(input string tag, input int rel);
    expect_byte({tag, "_i38"}, 1'b0, 8'h38, 5);
    expect_byte({tag, "_i0c"}, 1'b0, 8'h0C, 5);
    expect_byte({tag, "_i06"}, 1'b0, 8'h06, 5);
    expect_byte({tag, "_i01"}, 1'b0, 8'h01, 10);
    check({tag, "_init_len"}, 32'(cyc - rel), 32'd53);
    check({tag, "_init_busy"}, 32'(Busy), 32'd0);
    check({tag, "_init_nodone"}, 32'(Done), 32'd0);
  endtask

  task automatic check_refresh(input string tag, input frame_t fr);
    int g, st;
    g = 0;
    while (!LCD_EN && g < 1000) begin
      @(negedge clk);
      g++;
    end
    st = cyc;
    check({tag, "_busy_start"}, 32'(Busy), 32'd1);
    expect_byte({tag, "_a80"}, 1'b0, 8'h80, 5);
    for (int i = 0; i < 16; i++) expect_byte($sformatf("%s_c%0d", tag, i), 1'b1, fr[i], 5);
    expect_byte({tag, "_ac0"}, 1'b0, 8'hC0, 5);
    for (int i = 16; i < 32; i++) expect_byte($sformatf("%s_c%0d", tag, i), 1'b1, fr[i], 5);
    check({tag, "_busy_len"}, 32'(cyc - st), 32'd238);
    check({tag, "_busy_end"}, 32'(Busy), 32'd0);
    check({tag, "_done"}, 32'(Done), 32'd1);
    @(negedge clk);
    check({tag, "_done_1cyc"}, 32'(Done), 32'd0);
  endtask

  initial begin
    int   r, d0, g, k, en_hi;
    logic prev, pulsed;

    frame_a = mk_frame("P1:0 P2:0 LVL:0 ", "HUMAN  vs  AI   ");
    frame_b = frame_a;
    frame_b[5] = 8'h39;

    // 1: reset values, then the init sequence and its cycle budget
    repeat (3) @(negedge clk);
    check_reset_vals("rst_hold");
    reset = 1'b1;
    r = cyc;
    #1;
    check_reset_vals("rst_release");
    check_init("s1", r);

    // 2: single-cycle update pulse refreshes the full frame
    ascii = frame_a;
    @(negedge clk);
    d0 = done_cnt;
    UpdateLCD = 1'b1;
    @(negedge clk);
    UpdateLCD = 1'b0;
    check_refresh("s2", frame_a);
    repeat (5) @(negedge clk);
    check("s2_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 3: three edges mid-refresh collapse to one follow-up refresh using the IDLE-time ASCII
    d0 = done_cnt;
    UpdateLCD = 1'b1;
    @(negedge clk);
    UpdateLCD = 1'b0;
    fork
      check_refresh("s3a", frame_a);
      begin
        repeat (20) @(negedge clk);
        ascii[5] = 8'h38;
        for (int p = 0; p < 3; p++) begin
          UpdateLCD = 1'b1;
          @(negedge clk);
          UpdateLCD = 1'b0;
          repeat (30) @(negedge clk);
        end
        repeat (60) @(negedge clk);
        ascii[5] = 8'h39;
      end
    join
    check("s3_back2back", 32'(Busy), 32'd1);
    check_refresh("s3b", frame_b);
    repeat (300) @(negedge clk);
    check("s3_idle", 32'(Busy), 32'd0);
    check("s3_done_cnt", 32'(done_cnt - d0), 32'd2);

    // 4: a held-high trigger refreshes once only
    d0 = done_cnt;
    UpdateLCD = 1'b1;
    fork
      check_refresh("s4", frame_b);
      repeat (500) @(negedge clk);
    join
    UpdateLCD = 1'b0;
    repeat (20) @(negedge clk);
    check("s4_idle", 32'(Busy), 32'd0);
    check("s4_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 5: edge during power-up waits for init, then refresh starts after one idle cycle
    ascii = frame_a;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    r = cyc;
    fork
      check_init("s5", r);
      begin
        repeat (10) @(negedge clk);
        UpdateLCD = 1'b1;
        @(negedge clk);
        UpdateLCD = 1'b0;
      end
    join
    @(negedge clk);
    check("s5_busy_gap", 32'(Busy), 32'd1);
    check_refresh("s5r", frame_a);

    // 6: reset at byte 10 (with a pending edge) aborts and the restart shows no refresh
    d0 = done_cnt;
    UpdateLCD = 1'b1;
    @(negedge clk);
    UpdateLCD = 1'b0;
    g = 0;
    k = 0;
    prev = 1'b0;
    pulsed = 1'b0;
    while (g < 2000) begin
      if (LCD_EN && !prev) k++;
      prev = LCD_EN;
      if (k == 11) break;
      UpdateLCD = (k == 6) && !pulsed;
      if (k == 6) pulsed = 1'b1;
      @(negedge clk);
      g++;
    end
    check("s6_reach_byte10", 32'(k), 32'd11);
    reset = 1'b0;
    #1;
    check_reset_vals("s6_abort");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    r = cyc;
    check_init("s6", r);
    en_hi = 0;
    repeat (300) begin
      @(negedge clk);
      if (LCD_EN) en_hi++;
    end
    check("s6_no_refresh", 32'(en_hi), 32'd0);
    check("s6_idle", 32'(Busy), 32'd0);
    check("s6_done_cnt", 32'(done_cnt - d0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
